// File: rtl/cm0ik_sram_arb_pkg.sv
// ============================================================================
// Module   : cm0ik_sram_arb_pkg
// Brief    : Shared encodings for the two-port SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cm0ik_sram_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t  c_st_idle = 2'd0;
  localparam arb_state_t  c_st_own0 = 2'd1;
  localparam arb_state_t  c_st_own1 = 2'd2;

  localparam int unsigned c_port0   = 0;
  localparam int unsigned c_port1   = 1;

  localparam logic [3:0]  c_we_read = 4'h0;

endpackage

`default_nettype wire

// File: rtl/cm0ik_sram_arb_mux.sv
// ============================================================================
// Module   : cm0ik_sram_arb_mux
// Brief    : Drives the SRAM pins from whichever port holds the one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cm0ik_sram_arb_mux
  import cm0ik_sram_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 18,
  parameter int DATAWIDTH = 32
) (
  input  logic [1:0]           gnt_i,
  input  logic [ADDRWIDTH-1:0] addr0_i,
  input  logic [ADDRWIDTH-1:0] addr1_i,
  input  logic [3:0]           we0_i,
  input  logic [3:0]           we1_i,
  input  logic [DATAWIDTH-1:0] wdata0_i,
  input  logic [DATAWIDTH-1:0] wdata1_i,
  output logic                 scs_o,
  output logic [ADDRWIDTH-1:0] saddr_o,
  output logic [3:0]           swe_o,
  output logic [DATAWIDTH-1:0] swdata_o
);

  // Idle pins are forced to zero so the SRAM sees no stray writes.
  always_comb begin
    scs_o    = 1'b0;
    saddr_o  = '0;
    swe_o    = '0;
    swdata_o = '0;
    if (gnt_i[c_port0]) begin
      scs_o    = 1'b1;
      saddr_o  = addr0_i;
      swe_o    = we0_i;
      swdata_o = wdata0_i;
    end else if (gnt_i[c_port1]) begin
      scs_o    = 1'b1;
      saddr_o  = addr1_i;
      swe_o    = we1_i;
      swdata_o = wdata1_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cm0ik_sram_arb.sv
// ============================================================================
// Module   : cm0ik_sram_arb
// Brief    : Two-port SRAM arbiter; round-robin with burst tenure limit when
//            CM0IK_SRAM_ARB_RR_EN is defined, fixed port-0 priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cm0ik_sram_arb
  import cm0ik_sram_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 18,
  parameter int DATAWIDTH = 32,
  parameter int MAXBURST  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [ADDRWIDTH-1:0] ADDR0,
  input  logic [ADDRWIDTH-1:0] ADDR1,
  input  logic [3:0]           WE0,
  input  logic [3:0]           WE1,
  input  logic [DATAWIDTH-1:0] WDATA0,
  input  logic [DATAWIDTH-1:0] WDATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 RVALID0,
  output logic                 RVALID1,
  output logic [DATAWIDTH-1:0] RDATA0,
  output logic [DATAWIDTH-1:0] RDATA1,
  output logic                 SCS,
  output logic [ADDRWIDTH-1:0] SADDR,
  output logic [3:0]           SWE,
  output logic [DATAWIDTH-1:0] SWDATA,
  input  logic [DATAWIDTH-1:0] SRDATA
);

  arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [1:0] rtag_q, rtag_d;
  logic [1:0] w_gnt;
  logic [3:0] w_cnt_inc;

`ifdef CM0IK_SRAM_ARB_RR_EN
  localparam logic [3:0] c_burst_last = 4'(MAXBURST - 1);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{4'(MAXBURST), last_q};
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      rtag_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rtag_q  <= rtag_d;
    end
  end

  assign w_cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

  // cnt_q is the index of the previous grant within the current tenure.
  always_comb begin
    state_d = c_st_idle;
    cnt_d   = 4'd0;
    last_d  = last_q;
    case (state_q)
      c_st_own0: begin
`ifdef CM0IK_SRAM_ARB_RR_EN
        if (REQ0 && (!REQ1 || (cnt_q < c_burst_last))) begin
`else
        if (REQ0) begin
`endif
          state_d = c_st_own0;
          cnt_d   = w_cnt_inc;
        end else begin
          state_d = REQ1 ? c_st_own1 : c_st_idle;
          last_d  = 1'b0;
        end
      end
      c_st_own1: begin
`ifdef CM0IK_SRAM_ARB_RR_EN
        if (REQ1 && (!REQ0 || (cnt_q < c_burst_last))) begin
`else
        if (REQ1 && !REQ0) begin
`endif
          state_d = c_st_own1;
          cnt_d   = w_cnt_inc;
        end else begin
          state_d = REQ0 ? c_st_own0 : c_st_idle;
          last_d  = 1'b1;
        end
      end
      default: begin
`ifdef CM0IK_SRAM_ARB_RR_EN
        if (REQ0 && (!REQ1 || last_q)) begin
`else
        if (REQ0) begin
`endif
          state_d = c_st_own0;
        end else if (REQ1) begin
          state_d = c_st_own1;
        end
      end
    endcase
  end

  always_comb begin
    w_gnt                = 2'b00;
    w_gnt[c_port0]       = (state_d == c_st_own0);
    w_gnt[c_port1]       = (state_d == c_st_own1);
    rtag_d               = 2'b00;
    rtag_d[c_port0]      = w_gnt[c_port0] && (WE0 == c_we_read);
    rtag_d[c_port1]      = w_gnt[c_port1] && (WE1 == c_we_read);
  end

  assign GNT0    = w_gnt[c_port0];
  assign GNT1    = w_gnt[c_port1];
  assign RVALID0 = rtag_q[c_port0];
  assign RVALID1 = rtag_q[c_port1];
  assign RDATA0  = SRDATA;
  assign RDATA1  = SRDATA;

  cm0ik_sram_arb_mux #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (DATAWIDTH)
  ) u_mux (
    .gnt_i    (w_gnt),
    .addr0_i  (ADDR0),
    .addr1_i  (ADDR1),
    .we0_i    (WE0),
    .we1_i    (WE1),
    .wdata0_i (WDATA0),
    .wdata1_i (WDATA1),
    .scs_o    (SCS),
    .saddr_o  (SADDR),
    .swe_o    (SWE),
    .swdata_o (SWDATA)
  );

endmodule

`default_nettype wire

// File: tb/tb_cm0ik_sram_arb.sv
// ============================================================================
// Module   : tb_cm0ik_sram_arb
// Brief    : Directed bench for cm0ik_sram_arb with a small behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cm0ik_sram_arb;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ0 = 1'b0, REQ1 = 1'b0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [3:0]    WE0 = 4'h0, WE1 = 4'h0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
  logic          GNT0, GNT1, RVALID0, RVALID1, SCS;
  logic [DW-1:0] RDATA0, RDATA1, SWDATA;
  logic [AW-1:0] SADDR;
  logic [3:0]    SWE;
  logic [DW-1:0] SRDATA = '0;

  logic [31:0]   mem [256];
  int            errors = 0;
  int            checks = 0;

  cm0ik_sram_arb #(
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW),
    .MAXBURST  (4)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .ADDR0   (ADDR0),
    .ADDR1   (ADDR1),
    .WE0     (WE0),
    .WE1     (WE1),
    .WDATA0  (WDATA0),
    .WDATA1  (WDATA1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .RVALID0 (RVALID0),
    .RVALID1 (RVALID1),
    .RDATA0  (RDATA0),
    .RDATA1  (RDATA1),
    .SCS     (SCS),
    .SADDR   (SADDR),
    .SWE     (SWE),
    .SWDATA  (SWDATA),
    .SRDATA  (SRDATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM: read data appears one cycle after a selected read.
  always @(posedge CLK) begin
    if (SCS) begin
      if (SWE == 4'h0) begin
        SRDATA <= mem[SADDR[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (SWE[b]) mem[SADDR[7:0]][8*b +: 8] <= SWDATA[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0, e1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344;

    // Reset state
    #3;
    chk("rst_gnt0", 32'(GNT0), 32'd0);
    chk("rst_gnt1", 32'(GNT1), 32'd0);
    chk("rst_scs", 32'(SCS), 32'd0);
    chk("rst_rv0", 32'(RVALID0), 32'd0);
    chk("rst_rv1", 32'(RVALID1), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // Single port-0 read
    REQ0 = 1'b1; ADDR0 = 18'h00010; WE0 = 4'h0;
    #2;
    chk("rd0_gnt0", 32'(GNT0), 32'd1);
    chk("rd0_gnt1", 32'(GNT1), 32'd0);
    chk("rd0_scs", 32'(SCS), 32'd1);
    chk("rd0_saddr", 32'(SADDR), 32'h10);
    chk("rd0_swe", 32'(SWE), 32'd0);
    tick();
    REQ0 = 1'b0;
    chk("rd0_rv0", 32'(RVALID0), 32'd1);
    chk("rd0_rdata", RDATA0, 32'hDEADBEEF);
    chk("rd0_rv1", 32'(RVALID1), 32'd0);
    #2;
    chk("idle_scs", 32'(SCS), 32'd0);
    chk("idle_saddr", 32'(SADDR), 32'd0);
    tick();

    // Port-1 byte write followed by read-back
    REQ1 = 1'b1; ADDR1 = 18'h00020; WE1 = 4'b0010; WDATA1 = 32'h0000AB00;
    #2;
    chk("wr1_gnt1", 32'(GNT1), 32'd1);
    chk("wr1_swe", 32'(SWE), 32'h2);
    chk("wr1_swdata", SWDATA, 32'h0000AB00);
    tick();
    chk("wr1_rv1", 32'(RVALID1), 32'd0);
    WE1 = 4'h0; WDATA1 = '0;
    #2;
    chk("rd1_gnt1", 32'(GNT1), 32'd1);
    tick();
    REQ1 = 1'b0;
    chk("rd1_rv1", 32'(RVALID1), 32'd1);
    chk("rd1_rdata", RDATA1, 32'h1122AB44);
    chk("rd1_rv0", 32'(RVALID0), 32'd0);
    tick();

    // Contention: both ports read continuously
    REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 4'h0; WE1 = 4'h0;
    for (int i = 0; i < 12; i++) begin
`ifdef CM0IK_SRAM_ARB_RR_EN
      e0 = ((i / 4) % 2) == 0;
`else
      e0 = 1'b1;
`endif
      e1 = !e0;
      #2;
      chk($sformatf("cont_gnt0_%0d", i), 32'(GNT0), 32'(e0));
      chk($sformatf("cont_gnt1_%0d", i), 32'(GNT1), 32'(e1));
      chk($sformatf("cont_excl_%0d", i), 32'(GNT0 & GNT1), 32'd0);
      tick();
      chk($sformatf("cont_rv0_%0d", i), 32'(RVALID0), 32'(e0));
      chk($sformatf("cont_rv1_%0d", i), 32'(RVALID1), 32'(e1));
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();

    // Port 1 owns, then port 0 rises
    REQ1 = 1'b1;
    #2;
    chk("pre_gnt1", 32'(GNT1), 32'd1);
    tick();
    REQ0 = 1'b1;
    #2;
`ifdef CM0IK_SRAM_ARB_RR_EN
    chk("preempt_gnt0", 32'(GNT0), 32'd0);
    chk("preempt_gnt1", 32'(GNT1), 32'd1);
`else
    chk("preempt_gnt0", 32'(GNT0), 32'd1);
    chk("preempt_gnt1", 32'(GNT1), 32'd0);
`endif
    tick();
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    tick();

    // Uncontended port-1 stream of 20 reads
    REQ1 = 1'b1; ADDR1 = 18'h00010;
    for (int i = 0; i < 20; i++) begin
      #2;
      chk($sformatf("strm_gnt1_%0d", i), 32'(GNT1), 32'd1);
      tick();
      chk($sformatf("strm_rd_%0d", i), RDATA1, 32'hDEADBEEF);
    end
    REQ1 = 1'b0;
    tick();

    // Reset pulsed one cycle after a granted read
    REQ0 = 1'b1; ADDR0 = 18'h00010; WE0 = 4'h0;
    #2;
    chk("rr_gnt0", 32'(GNT0), 32'd1);
    tick();
    REQ0 = 1'b0;
    chk("rr_rv0_pre", 32'(RVALID0), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rr_rv0_async", 32'(RVALID0), 32'd0);
    tick();
    RESET = 1'b0;
    #1;
    chk("rr_rv0_post", 32'(RVALID0), 32'd0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    #1;
    chk("rr_tie_gnt0", 32'(GNT0), 32'd1);
    chk("rr_tie_gnt1", 32'(GNT1), 32'd0);
    tick();
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cm0ik_sram_arb.md
# cm0ik_sram_arb

Two-requester arbiter that shares one `cm0ik_sram` instance between the processor-side memory interface (port 0) and a secondary master such as a DMA or debug loader (port 1). It handles request/grant, a burst-tenure limit and round-robin fairness. It drives the SRAM address, chip-select, byte-enable and write-data pins from the granted port. It steers the one-cycle-late read-data valid back to the port that issued the read. It sits directly between the integration-kit bus adapters and the SRAM model in the cm0ikmcu memory subsystem.

## Interface
- ADDRWIDTH, 18: SRAM word-address width; must match the attached SRAM.
- DATAWIDTH, 32: data width; fixed at 32 because byte enables are 4 bits.
- MAXBURST, 4: maximum consecutive grants to one port while the other port is requesting; legal range 1..15.

- CLK  in  1  single clock; all state on its rising edge.
- RESET  in  1  reset, asynchronous assert, active-high.
- REQ0 / REQ1  in  1  access request, held until granted.
- ADDR0 / ADDR1  in  ADDRWIDTH  word address.
- WE0 / WE1  in  4  byte write enables; 4'h0 means read.
- WDATA0 / WDATA1  in  DATAWIDTH  write data.
- GNT0 / GNT1  out  1  combinational grant; the access is taken at this cycle's clock edge.
- RVALID0 / RVALID1  out  1  registered; read data valid for that port.
- RDATA0 / RDATA1  out  DATAWIDTH  both driven directly from SRDATA; qualified by RVALIDx.
- SCS  out  1  SRAM chip select.
- SADDR  out  ADDRWIDTH  SRAM address.
- SWE  out  4  SRAM byte write enables.
- SWDATA  out  DATAWIDTH  SRAM write data.
- SRDATA  in  DATAWIDTH  SRAM read data, valid one cycle after a read-enabled edge.

## Operation
- State register takes one of three values:
  - IDLE: no owner.
  - OWN0: port 0 holds the grant.
  - OWN1: port 1 holds the grant.
- Other registers:
  - tenure counter `cnt`, 4 bits.
  - last-owner pointer `last`, 1 bit.
  - read tag `rtag`, 2 bits, one-hot per port.
- IDLE transitions:
  - One port requests: grant it, cnt=0.
  - Both request: grant port !last.
- OWNx transitions:
  - REQx high and (other port idle or cnt<MAXBURST-1): keep x, cnt++. Counter saturates at 15 when the other port is idle.
  - Otherwise, if the other port requests: switch to it, cnt=0, last=x.
  - Otherwise: go to IDLE, last=x.
- Grant is combinational from next-state. GNTx=1 exactly when the SRAM pins carry port x this cycle.
- Both GNT outputs are never high together.
- With no grant: SCS=0, SADDR=0, SWE=0, SWDATA=0.
- With a grant: SCS=1 and SADDR, SWE, SWDATA are muxed from the granted port.
- Read tracking:
  - On a granted read (WEx==0), rtag[x] is set for the next cycle, so RVALIDx=1 one cycle after GNTx.
  - Writes never raise RVALID.
- A requester may drop REQ at any time. A dropped REQ with no grant is simply not serviced.

## Timing
- Reset values:
  - State IDLE, cnt=0, last=1 (so port 0 wins the first tie), rtag=0.
  - RVALID0=RVALID1=0, GNT0=GNT1=0, SCS=0.
- Latency:
  - Grant: 0 cycles from REQ when the SRAM is free.
  - Read data: GNT cycle + 1.
  - Back-to-back grants give 1 access per cycle.
- Simultaneous REQ in IDLE: resolved by `last`.
- Contended streams alternate in tenures of exactly MAXBURST cycles.
- MAXBURST=1 gives strict per-cycle alternation under contention.
- Handover is bubble-free: the last grant to port x and the first grant to port y are adjacent cycles.
- Reset asserted mid-read: the pending RVALID is cleared asynchronously, and the read data is discarded.

## Configuration
- CM0IK_SRAM_ARB_RR_EN defined: round-robin with the MAXBURST tenure limit as above.
- Not defined: fixed priority.
  - Port 0 wins every tie and preempts an OWN1 tenure in the cycle REQ0 rises.
  - Port 0 tenure is unlimited.
  - MAXBURST and `last` are unused (`last` may be optimised away).

## Structure
- Package `cm0ik_sram_arb_pkg` holds:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - port index constants;
  - a localparam for the WE read encoding, 4'h0.
- One sub-module `cm0ik_sram_arb_mux` is natural: the purely combinational port-select mux driving SCS, SADDR, SWE and SWDATA from a one-hot grant.
- FSM, counter and read tag stay in the top module.

## Test plan
- Reset then single port-0 read: REQ0=1, ADDR0=0x00010, WE0=0 → GNT0 the same cycle; RVALID0=1 next cycle with RDATA0 equal to the preloaded word 0xDEADBEEF; RVALID1 stays 0.
- Byte write then read on port 1: WE1=4'b0010, WDATA1=0x0000AB00 to a word holding 0x11223344 → a later read returns 0x1122AB44; no RVALID on the write.
- Simultaneous REQ0/REQ1 held high with MAXBURST=4 and RR enabled → grant pattern 0,0,0,0,1,1,1,1,0…; never both GNT high; each RVALID follows its own grant by 1 cycle.
- Same contention without CM0IK_SRAM_ARB_RR_EN → GNT0 continuous, GNT1=0. REQ1 alone then REQ0 rising → GNT1 drops and GNT0 rises in the same cycle.
- Uncontended port-1 stream of 20 reads → 20 consecutive grants with no forced yield; cnt saturates without wrap.
- RESET pulsed one cycle after a granted read → RVALID0 is 0 immediately; after release, state is IDLE and the next tie goes to port 0.
